// File: rtl/mc_stall_ctrl_if.sv
// Signal bundle between the stall controller and the pipeline/divider.
// Handshake: div_start_o launches the divider for one cycle; the divider answers with div_ready_i, the controller annuls it with div_annul_o on flush or timeout.
interface mc_stall_ctrl_if;
  logic       stallreq_id;
  logic       macc_req;
  logic       div_req;
  logic       div_ready_i;
  logic       flush_i;
  logic [5:0] pause;
  logic [1:0] cnt_o;
  logic       div_start_o;
  logic       div_annul_o;
  logic       busy_o;
  logic       div_timeout_o;
  logic [1:0] state_o;

  modport master (
    input  stallreq_id, macc_req, div_req, div_ready_i, flush_i,
    output pause, cnt_o, div_start_o, div_annul_o, busy_o, div_timeout_o, state_o
  );

  modport slave (
    output stallreq_id, macc_req, div_req, div_ready_i, flush_i,
    input  pause, cnt_o, div_start_o, div_annul_o, busy_o, div_timeout_o, state_o
  );
endinterface

// File: rtl/mc_stall_ctrl.sv
// Pipeline stall controller and EX multi-cycle sequencer (madd/msub, div/divu).
// Combinational outputs are forced quiet while rst is low so reset takes effect immediately.
module mc_stall_ctrl #(
  parameter int DIV_TIMEOUT = 36,
  parameter int CNT_W       = 6
) (
  input  logic           clk,
  input  logic           rst,
  mc_stall_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MACC2    = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             ex_stall;
  logic             start;
  logic             annul;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    ex_stall  = 1'b0;
    start     = 1'b0;
    annul     = 1'b0;
    if (bus.flush_i) begin
      // Flush wins over everything; only a running divide needs cancelling.
      state_d = IDLE;
      cnt_d   = '0;
      annul   = (state_q == DIV_RUN);
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.div_req) begin
            start    = 1'b1;
            ex_stall = 1'b1;
            cnt_d    = '0;
            state_d  = DIV_RUN;
          end else if (bus.macc_req) begin
            ex_stall = 1'b1;
            state_d  = MACC2;
          end
        end
        MACC2: begin
          state_d = IDLE;
        end
        DIV_RUN: begin
          ex_stall = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (bus.div_ready_i) begin
            state_d = DIV_DONE;
          end else if (cnt_q == CNT_LAST) begin
            annul     = 1'b1;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
        DIV_DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // EX stall covers the ID stall; MEM/WB keep flowing so ex_mem inserts a bubble.
  always_comb begin
    bus.pause = 6'b000000;
    if (rst) begin
      if (ex_stall) begin
        bus.pause = 6'b001111;
      end else if (bus.stallreq_id) begin
        bus.pause = 6'b000111;
      end
    end
  end

  assign bus.cnt_o         = (rst && state_q == MACC2) ? 2'b01 : 2'b00;
  assign bus.div_start_o   = rst & start;
  assign bus.div_annul_o   = rst & annul;
  assign bus.busy_o        = rst & (state_q != IDLE);
  assign bus.div_timeout_o = timeout_q;
  assign bus.state_o       = state_q;

endmodule

// File: tb/tb_mc_stall_ctrl.sv
// Bench for mc_stall_ctrl: directed vector table, hand sequences for divide/timeout/flush/reset,
// then random traffic against a transaction-level model.
module tb_mc_stall_ctrl;
  localparam int DIV_TIMEOUT = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mc_stall_ctrl_if bus();

  mc_stall_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic       sr, mc, dv, rd, fl;
    logic [5:0] pause;
    logic [1:0] cnt;
    logic       start, annul, busy;
  } vec_t;

  vec_t vecs[18];

  // Packed view: {pause, cnt, start, annul, busy, timeout}
  function automatic logic [11:0] pk(input logic [5:0] p, input logic [1:0] c,
                                     input logic s, input logic a, input logic b, input logic t);
    return {p, c, s, a, b, t};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.pause, bus.cnt_o, bus.div_start_o, bus.div_annul_o, bus.busy_o, bus.div_timeout_o};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual pause/cnt/st/an/bz/to=%b required=%b", name, act, exp);
    end
  endtask

  task automatic drive(input logic sr, input logic mc, input logic dv, input logic rd, input logic fl);
    bus.stallreq_id = sr;
    bus.macc_req    = mc;
    bus.div_req     = dv;
    bus.div_ready_i = rd;
    bus.flush_i     = fl;
  endtask

  task automatic cyc(input logic sr, input logic mc, input logic dv, input logic rd, input logic fl);
    @(posedge clk);
    #1;
    drive(sr, mc, dv, rd, fl);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic sr, input logic mc, input logic dv, input logic rd,
                              input logic fl, input logic [5:0] p, input logic [1:0] c,
                              input logic s, input logic a, input logic b);
    vec_t v;
    v.sr = sr; v.mc = mc; v.dv = dv; v.rd = rd; v.fl = fl;
    v.pause = p; v.cnt = c; v.start = s; v.annul = a; v.busy = b;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    // model state: what is in flight, described by elapsed divide cycles
    int  m_div_age;
    bit  m_macc_tail, m_div_result, m_to;
    bit  sr, mc, dv, rd, fl;
    bit  idle, run, launch_div, launch_macc, last, hold_ex;
    logic [5:0] ep;

    // ---- reset with requests asserted: outputs must stay quiet
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    check("reset_quiet", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("after_reset", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // ---- vector table
    vecs[0]  = mk(1, 0, 0, 0, 0, 6'b000111, 2'b00, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 0, 6'b001111, 2'b00, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 6'b000000, 2'b01, 0, 0, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 6'b001111, 2'b00, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 6'b000111, 2'b01, 0, 0, 1);
    vecs[7]  = mk(0, 1, 0, 0, 1, 6'b000000, 2'b00, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 6'b001111, 2'b00, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1, 6'b000000, 2'b01, 0, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    vecs[12] = mk(0, 0, 1, 0, 1, 6'b000000, 2'b00, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    vecs[14] = mk(0, 1, 1, 0, 0, 6'b001111, 2'b00, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 0, 6'b001111, 2'b00, 0, 0, 1);
    vecs[16] = mk(0, 0, 1, 0, 0, 6'b000000, 2'b00, 0, 0, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 6'b000000, 2'b00, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].sr, vecs[i].mc, vecs[i].dv, vecs[i].rd, vecs[i].fl);
      check($sformatf("vec%0d", i), obs(),
            pk(vecs[i].pause, vecs[i].cnt, vecs[i].start, vecs[i].annul, vecs[i].busy, 1'b0));
    end

    // ---- divide with ready after 32 run cycles, macc at launch ignored
    cyc(0, 1, 1, 0, 0);
    check("div32_launch", obs(), pk(6'b001111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 0, (k == 32), 0);
      check($sformatf("div32_run%0d", k), obs(), pk(6'b001111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    end
    cyc(0, 0, 1, 0, 0);
    check("div32_done", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
    cyc(0, 0, 0, 0, 0);
    check("div32_idle", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // ---- divide that never completes
    cyc(0, 0, 1, 0, 0);
    check("to_launch", obs(), pk(6'b001111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 1; k <= DIV_TIMEOUT; k++) begin
      cyc(0, 0, 0, 0, 0);
      check($sformatf("to_run%0d", k), obs(),
            pk(6'b001111, 2'b00, 1'b0, (k == DIV_TIMEOUT), 1'b1, 1'b0));
    end
    cyc(0, 0, 0, 0, 0);
    check("to_idle", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));
    cyc(1, 0, 0, 0, 0);
    check("to_sticky", obs(), pk(6'b000111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    // ---- flush in the fifth run cycle
    cyc(0, 0, 1, 0, 0);
    check("fl_launch", obs(), pk(6'b001111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0);
      check($sformatf("fl_run%0d", k), obs(), pk(6'b001111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    end
    cyc(0, 0, 0, 0, 1);
    check("fl_flush", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1));
    cyc(0, 0, 0, 0, 0);
    check("fl_idle", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1));

    // ---- asynchronous reset in the middle of a divide
    cyc(0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) cyc(1, 0, 1, 0, 0);
    check("ar_before", obs(), pk(6'b001111, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    #2;
    rst = 1'b0;
    #1;
    check("ar_immediate", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ar_release", obs(), pk(6'b000000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));

    // ---- random traffic against the model
    m_div_age = -1;
    m_macc_tail = 1'b0;
    m_div_result = 1'b0;
    m_to = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sr = ($urandom_range(0, 3) == 0);
      mc = ($urandom_range(0, 4) == 0);
      dv = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 39) == 0);
      fl = ($urandom_range(0, 49) == 0);

      idle        = (m_div_age < 0) && !m_macc_tail && !m_div_result;
      run         = (m_div_age >= 0);
      launch_div  = idle && dv && !fl;
      launch_macc = idle && !dv && mc && !fl;
      last        = run && !rd && (m_div_age == DIV_TIMEOUT - 1);
      hold_ex     = launch_div || launch_macc || (run && !fl);
      ep          = hold_ex ? 6'b001111 : (sr ? 6'b000111 : 6'b000000);
      exp_q.push_back(pk(ep, m_macc_tail ? 2'b01 : 2'b00, launch_div,
                         run && (fl || last), !idle, m_to));

      cyc(sr, mc, dv, rd, fl);
      check($sformatf("rand%0d", c), obs(), exp_q.pop_front());

      if (fl) begin
        m_div_age = -1;
        m_macc_tail = 1'b0;
        m_div_result = 1'b0;
      end else if (launch_div) begin
        m_div_age = 0;
      end else if (launch_macc) begin
        m_macc_tail = 1'b1;
      end else if (m_macc_tail) begin
        m_macc_tail = 1'b0;
      end else if (m_div_result) begin
        m_div_result = 1'b0;
      end else if (run) begin
        if (rd) begin
          m_div_age = -1;
          m_div_result = 1'b1;
        end else if (last) begin
          m_div_age = -1;
          m_to = 1'b1;
        end else begin
          m_div_age++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
